// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared encodings for the MIPS pipeline hazard controller
// Purpose: FSM state encoding for the mul/div occupancy tracker and the
//          architectural zero-register address.
// Contents: md_state_e (ST_RUN=1'b0, ST_MD_WAIT=1'b1), REG_ZERO (5'd0)
package mips_pkg;

  typedef enum logic {
    ST_RUN     = 1'b0,
    ST_MD_WAIT = 1'b1
  } md_state_e;

  localparam logic [4:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/md_occupancy_cnt.sv
// rtl/md_occupancy_cnt.sv - remaining-cycle counter for a mul/div occupying EX
// Purpose: loadable down-counter that saturates at zero and flags zero.
// Ports:
//   clk      in  1  clock
//   rst      in  1  synchronous reset, active-high (counter -> 0)
//   clr      in  1  abort: counter -> 0
//   load     in  1  load load_val (lower priority than clr)
//   load_val in  W  value to load
//   dec      in  1  decrement by one, holding at 0
//   zero     out 1  counter is 0
module md_occupancy_cnt #(
  parameter int W = 5
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         zero
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (dec && (cnt != '0)) begin
      cnt <= cnt - W'(1);
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// rtl/pipeline_hazard_ctrl.sv - En/Clr sequencing of the 5-stage MIPS pipeline registers
// Purpose: resolves load-use stalls, taken-branch and jump flushes, mul/div
//          occupancy of EX and data-memory wait freezes into pipeline-register
//          enable/clear controls. Outputs are combinational from state + inputs.
// Optional feature: HAZARD_PERF_EN adds stall_cnt / flush_cnt event counters.
// Ports:
//   clk, rst                 in   clock, synchronous active-high reset
//   ID_rs, ID_rt             in   AW  source registers of the ID instruction
//   ID_useRs, ID_useRt       in   1   ID instruction really reads rs / rt
//   ID_jump                  in   1   ID instruction is J/JAL/JR
//   EX_memRead, EX_wAddr     in   load flag / destination of the EX instruction
//   EX_mdStart               in   1   EX instruction is mul/div
//   MEM_brTaken              in   1   branch in MEM is taken
//   MEM_dReq, MEM_dReady     in   1   data-memory request / completion
//   PC_En                    out  1   PC load enable
//   IF_En/IF_Clr, ID_En/ID_Clr, EX_En/EX_Clr  out  pipeline register controls
//   MEM_En                   out  1   MEM/WB enable
//   MD_busy, MD_done         out  1   mul/div in progress / result valid pulse
//   stall_cnt, flush_cnt     out  32  (HAZARD_PERF_EN only) event counters
module pipeline_hazard_ctrl
  import mips_pkg::*;
#(
  parameter int MULDIV_CYCLES = 32,
  parameter int AW            = 5
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [AW-1:0] ID_rs,
  input  logic [AW-1:0] ID_rt,
  input  logic          ID_useRs,
  input  logic          ID_useRt,
  input  logic          ID_jump,
  input  logic          EX_memRead,
  input  logic [AW-1:0] EX_wAddr,
  input  logic          EX_mdStart,
  input  logic          MEM_brTaken,
  input  logic          MEM_dReq,
  input  logic          MEM_dReady,
  output logic          PC_En,
  output logic          IF_En,
  output logic          IF_Clr,
  output logic          ID_En,
  output logic          ID_Clr,
  output logic          EX_En,
  output logic          EX_Clr,
  output logic          MEM_En,
  output logic          MD_busy,
  output logic          MD_done
`ifdef HAZARD_PERF_EN
  ,
  output logic [31:0]   stall_cnt,
  output logic [31:0]   flush_cnt
`endif
);

  localparam int            CW      = $clog2(MULDIV_CYCLES);
  // The start cycle and the final (done) cycle are not counted, hence -2.
  localparam logic [CW-1:0] MD_LOAD = CW'(MULDIV_CYCLES - 2);

  md_state_e state;
  logic      cnt_zero;
  logic      memfrz;
  logic      lduse;
  logic      mdstl;
  logic      md_launch;
  logic      in_wait;

  assign in_wait = (state == ST_MD_WAIT);
  assign memfrz  = MEM_dReq & ~MEM_dReady;
  assign lduse   = EX_memRead & (EX_wAddr != AW'(REG_ZERO)) &
                   ((ID_useRs & (ID_rs == EX_wAddr)) | (ID_useRt & (ID_rt == EX_wAddr)));
  assign mdstl   = (~in_wait & EX_mdStart) | (in_wait & ~cnt_zero);

  // A new mul/div only starts when neither a freeze nor a branch abort overrides it.
  assign md_launch = ~memfrz & ~MEM_brTaken & ~in_wait & EX_mdStart;

  md_occupancy_cnt #(.W(CW)) u_md_cnt (
    .clk      (clk),
    .rst      (rst),
    .clr      (~memfrz & MEM_brTaken),
    .load     (md_launch),
    .load_val (MD_LOAD),
    .dec      (in_wait),
    .zero     (cnt_zero)
  );

  // A freeze holds state even at cnt==0, which is what withholds MD_done.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_RUN;
    end else if (memfrz) begin
      state <= state;
    end else if (MEM_brTaken) begin
      state <= ST_RUN;
    end else if (md_launch) begin
      state <= ST_MD_WAIT;
    end else if (in_wait && cnt_zero) begin
      state <= ST_RUN;
    end
  end

  always_comb begin
    PC_En   = 1'b1;
    IF_En   = 1'b1;
    ID_En   = 1'b1;
    EX_En   = 1'b1;
    MEM_En  = 1'b1;
    IF_Clr  = 1'b0;
    ID_Clr  = 1'b0;
    EX_Clr  = 1'b0;
    MD_busy = ~rst & in_wait;
    MD_done = ~rst & in_wait & cnt_zero & ~memfrz & ~MEM_brTaken;
    if (rst) begin
      IF_Clr = 1'b1;
      ID_Clr = 1'b1;
      EX_Clr = 1'b1;
    end else if (memfrz) begin
      PC_En  = 1'b0;
      IF_En  = 1'b0;
      ID_En  = 1'b0;
      EX_En  = 1'b0;
      MEM_En = 1'b0;
    end else if (MEM_brTaken) begin
      IF_Clr = 1'b1;
      ID_Clr = 1'b1;
      EX_Clr = 1'b1;
    end else if (mdstl) begin
      // EX is held in place; a bubble goes forward into MEM.
      PC_En  = 1'b0;
      IF_En  = 1'b0;
      ID_En  = 1'b0;
      EX_Clr = 1'b1;
    end else if (lduse) begin
      // Load advances; a bubble goes into EX while IF/ID hold.
      PC_En  = 1'b0;
      IF_En  = 1'b0;
      ID_Clr = 1'b1;
    end else if (ID_jump) begin
      IF_Clr = 1'b1;
    end
  end

`ifdef HAZARD_PERF_EN
  logic stall_fire;
  logic flush_fire;

  assign stall_fire = ~rst & (memfrz | (~MEM_brTaken & (mdstl | lduse)));
  assign flush_fire = ~rst & ~memfrz & (MEM_brTaken | (~mdstl & ~lduse & ID_jump));

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt <= 32'd0;
      flush_cnt <= 32'd0;
    end else begin
      if (stall_fire) stall_cnt <= stall_cnt + 32'd1;
      if (flush_fire) flush_cnt <= flush_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// tb/tb_pipeline_hazard_ctrl.sv - self-checking bench for pipeline_hazard_ctrl
module tb_pipeline_hazard_ctrl;

  typedef struct {
    string      name;
    logic       rst;
    logic [4:0] rs;
    logic [4:0] rt;
    logic       urs;
    logic       urt;
    logic       jmp;
    logic       mrd;
    logic [4:0] wa;
    logic       md;
    logic       br;
    logic       dq;
    logic       dr;
    logic [9:0] exp;  // {PC_En,IF_En,IF_Clr,ID_En,ID_Clr,EX_En,EX_Clr,MEM_En,MD_busy,MD_done}
  } vec_t;

  localparam logic [9:0] E_DEF  = 10'b1101010100;
  localparam logic [9:0] E_RST  = 10'b1111111100;
  localparam logic [9:0] E_BR   = 10'b1111111100;
  localparam logic [9:0] E_BRB  = 10'b1111111110;
  localparam logic [9:0] E_FRZ  = 10'b0000000000;
  localparam logic [9:0] E_FRZB = 10'b0000000010;
  localparam logic [9:0] E_MD0  = 10'b0000011100;
  localparam logic [9:0] E_MDB  = 10'b0000011110;
  localparam logic [9:0] E_DONE = 10'b1101010111;
  localparam logic [9:0] E_LD   = 10'b0001110100;
  localparam logic [9:0] E_JMP  = 10'b1111010100;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] ID_rs, ID_rt, EX_wAddr;
  logic       ID_useRs, ID_useRt, ID_jump, EX_memRead, EX_mdStart;
  logic       MEM_brTaken, MEM_dReq, MEM_dReady;
  logic       PC_En, IF_En, IF_Clr, ID_En, ID_Clr, EX_En, EX_Clr, MEM_En, MD_busy, MD_done;
`ifdef HAZARD_PERF_EN
  logic [31:0] stall_cnt, flush_cnt;
`endif

  int   checks = 0;
  int   errors = 0;
  vec_t sbq[$];
  vec_t tbl[$];

  always #5 clk = ~clk;

  pipeline_hazard_ctrl #(.MULDIV_CYCLES(4), .AW(5)) dut (
    .clk(clk), .rst(rst),
    .ID_rs(ID_rs), .ID_rt(ID_rt), .ID_useRs(ID_useRs), .ID_useRt(ID_useRt),
    .ID_jump(ID_jump), .EX_memRead(EX_memRead), .EX_wAddr(EX_wAddr),
    .EX_mdStart(EX_mdStart), .MEM_brTaken(MEM_brTaken),
    .MEM_dReq(MEM_dReq), .MEM_dReady(MEM_dReady),
    .PC_En(PC_En), .IF_En(IF_En), .IF_Clr(IF_Clr), .ID_En(ID_En), .ID_Clr(ID_Clr),
    .EX_En(EX_En), .EX_Clr(EX_Clr), .MEM_En(MEM_En), .MD_busy(MD_busy), .MD_done(MD_done)
`ifdef HAZARD_PERF_EN
    , .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
`endif
  );

  function automatic vec_t mk(string nm, logic r, logic [4:0] rs, logic [4:0] rt,
                              logic urs, logic urt, logic jmp, logic mrd, logic [4:0] wa,
                              logic md, logic br, logic dq, logic dr, logic [9:0] e);
    vec_t v;
    v.name = nm; v.rst = r; v.rs = rs; v.rt = rt; v.urs = urs; v.urt = urt;
    v.jmp = jmp; v.mrd = mrd; v.wa = wa; v.md = md; v.br = br; v.dq = dq; v.dr = dr;
    v.exp = e;
    return v;
  endfunction

  // Drive one cycle of stimulus just after the rising edge and queue its expectation.
  task automatic step(input vec_t v);
    @(posedge clk);
    #1;
    rst = v.rst; ID_rs = v.rs; ID_rt = v.rt; ID_useRs = v.urs; ID_useRt = v.urt;
    ID_jump = v.jmp; EX_memRead = v.mrd; EX_wAddr = v.wa; EX_mdStart = v.md;
    MEM_brTaken = v.br; MEM_dReq = v.dq; MEM_dReady = v.dr;
    sbq.push_back(v);
  endtask

  task automatic idle(input string nm, input logic [9:0] e);
    step(mk(nm, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, e));
  endtask

  task automatic md(input string nm, input logic br, input logic dq, input logic [9:0] e);
    step(mk(nm, 0, 0, 0, 0, 0, 0, 0, 0, 1, br, dq, 0, e));
  endtask

  always @(negedge clk) begin
    vec_t       e;
    logic [9:0] act;
    if (sbq.size() > 0) begin
      e   = sbq.pop_front();
      act = {PC_En, IF_En, IF_Clr, ID_En, ID_Clr, EX_En, EX_Clr, MEM_En, MD_busy, MD_done};
      checks++;
      if (act !== e.exp) begin
        errors++;
        $display("FAIL %s actual=%b expected=%b", e.name, act, e.exp);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; ID_rs = '0; ID_rt = '0; ID_useRs = 0; ID_useRt = 0; ID_jump = 0;
    EX_memRead = 0; EX_wAddr = '0; EX_mdStart = 0; MEM_brTaken = 0; MEM_dReq = 0; MEM_dReady = 0;

    //           name          rst rs  rt urs urt jmp mrd wa md br dq dr exp
    tbl.push_back(mk("rst0",      1, 0,  0, 0, 0, 0, 0, 0, 0, 0, 0, 0, E_RST));
    tbl.push_back(mk("rst1",      1, 0,  0, 0, 0, 0, 0, 0, 0, 0, 0, 0, E_RST));
    tbl.push_back(mk("post_rst",  0, 0,  0, 0, 0, 0, 0, 0, 0, 0, 0, 0, E_DEF));
    tbl.push_back(mk("lduse_rs",  0, 8,  0, 1, 0, 0, 1, 8, 0, 0, 0, 0, E_LD));
    tbl.push_back(mk("after_ld",  0, 8,  0, 1, 0, 0, 0, 3, 0, 0, 0, 0, E_DEF));
    tbl.push_back(mk("ld_r0",     0, 0,  0, 1, 0, 0, 1, 0, 0, 0, 0, 0, E_DEF));
    tbl.push_back(mk("lduse_rt",  0, 1,  9, 0, 1, 0, 1, 9, 0, 0, 0, 0, E_LD));
    tbl.push_back(mk("rt_unused", 0, 1,  9, 1, 0, 0, 1, 9, 0, 0, 0, 0, E_DEF));
    tbl.push_back(mk("no_load",   0, 8,  0, 1, 0, 0, 0, 8, 0, 0, 0, 0, E_DEF));
    tbl.push_back(mk("jump",      0, 0,  0, 0, 0, 1, 0, 0, 0, 0, 0, 0, E_JMP));
    tbl.push_back(mk("ld_jump",   0, 4,  0, 1, 0, 1, 1, 4, 0, 0, 0, 0, E_LD));
    tbl.push_back(mk("jump_retry",0, 4,  0, 1, 0, 1, 0, 4, 0, 0, 0, 0, E_JMP));
    tbl.push_back(mk("br_wins",   0, 4,  0, 1, 0, 1, 1, 4, 0, 1, 0, 0, E_BR));
    tbl.push_back(mk("frz_jump",  0, 0,  0, 0, 0, 1, 0, 0, 0, 1, 1, 0, E_FRZ));
    tbl.push_back(mk("dreq_rdy",  0, 0,  0, 0, 0, 0, 0, 0, 0, 0, 1, 1, E_DEF));
    foreach (tbl[i]) step(tbl[i]);

    // Mul/div full occupancy: stalled cycles 1-3, done in cycle 4.
    md("md_c1", 0, 0, E_MD0);
    md("md_c2", 0, 0, E_MDB);
    md("md_c3", 0, 0, E_MDB);
    md("md_c4_done", 0, 0, E_DONE);
    idle("md_c5", E_DEF);

    // Branch aborts a mul/div in its second cycle.
    md("ab_c1", 0, 0, E_MD0);
    md("ab_br", 1, 0, E_BRB);
    idle("ab_after", E_DEF);
    idle("ab_after2", E_DEF);

    // Freeze at cnt==0 withholds MD_done until release.
    md("fz_c1", 0, 0, E_MD0);
    md("fz_c2", 0, 0, E_MDB);
    md("fz_c3", 0, 0, E_MDB);
    md("fz_hold", 0, 1, E_FRZB);
    md("fz_done", 0, 0, E_DONE);
    idle("fz_after", E_DEF);

    // Freeze on the launch cycle delays the start; freeze mid-wait still counts down.
    md("fl_frz", 0, 1, E_FRZ);
    md("fl_c1", 0, 0, E_MD0);
    md("fl_c2frz", 0, 1, E_FRZB);
    md("fl_c3", 0, 0, E_MDB);
    md("fl_done", 0, 0, E_DONE);
    idle("fl_after", E_DEF);

    // Reset in the middle of MD_WAIT: no MD_done afterwards.
    md("rm_c1", 0, 0, E_MD0);
    md("rm_c2", 0, 0, E_MDB);
    step(mk("rm_rst", 1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, E_RST));
    idle("rm_after", E_DEF);
    idle("rm_after2", E_DEF);

    // Memory freeze over a load-use hazard, then the stall applies.
    for (int i = 0; i < 3; i++)
      step(mk($sformatf("frz_ld%0d", i), 0, 8, 0, 1, 0, 0, 1, 8, 0, 0, 1, 0, E_FRZ));
    step(mk("frz_ld_rdy", 0, 8, 0, 1, 0, 0, 1, 8, 0, 0, 1, 1, E_LD));
    idle("frz_ld_after", E_DEF);

`ifdef HAZARD_PERF_EN
    step(mk("pf_rst", 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, E_RST));
    step(mk("pf_ld", 0, 8, 0, 1, 0, 0, 1, 8, 0, 0, 0, 0, E_LD));
    step(mk("pf_br", 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, E_BR));
    idle("pf_idle", E_DEF);
    @(negedge clk);
    #1;
    checks++;
    if (stall_cnt !== 32'd1) begin
      errors++;
      $display("FAIL stall_cnt actual=%0d expected=1", stall_cnt);
    end
    checks++;
    if (flush_cnt !== 32'd1) begin
      errors++;
      $display("FAIL flush_cnt actual=%0d expected=1", flush_cnt);
    end
`endif

    @(posedge clk);
    @(negedge clk);
    #1;
    checks++;
    if (sbq.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain actual=%0d expected=0", sbq.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
